div_issue_ctrl: RTL and testbench

//  Initiator side of the multi-cycle divider handshake in the EXE stage.

---
 rtl/div_issue_ctrl.sv | 108 ++++++++++
 tb/tb_div_issue_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues one divide at a time to the iterative divider, buffers the result
// for writeback, flags RAW hazards on the in-flight rd, and handles flush and watchdog timeout.
module div_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int CTRL_W  = 64,
    parameter int TIMEOUT = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [WIDTH-1:0]  req_a,
    input  logic [WIDTH-1:0]  req_b,
    input  logic [4:0]        req_rd,
    input  logic [CTRL_W-1:0] req_ctrl,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    output logic              hazard_stall,
    output logic              div_start,
    output logic [1:0]        div_op,
    output logic [WIDTH-1:0]  div_a,
    output logic [WIDTH-1:0]  div_b,
    output logic              div_clear,
    input  logic              div_done,
    input  logic [WIDTH-1:0]  div_result,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic [WIDTH-1:0]  wb_data,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic              err_timeout
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
    localparam logic [6:0] LAST = 7'(TIMEOUT - 1);
    state_t     state;
    logic [6:0] cnt;
    logic       accept;
    logic       inflight;
    assign req_ready = !flush && (state == IDLE || (state == HOLD && wb_ready));
    assign accept    = req_valid && req_ready;
    // The held result stops counting as in flight the moment writeback takes it.
    assign inflight  = state == LAUNCH || state == WAIT || (state == HOLD && !wb_ready);
    assign hazard_stall = inflight && wb_rd != 5'd0 &&
                          ((use_rs1 && rs1 == wb_rd) || (use_rs2 && rs2 == wb_rd));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            div_start   <= 1'b0;
            div_clear   <= 1'b0;
            div_op      <= '0;
            div_a       <= '0;
            div_b       <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_ctrl     <= '0;
            err_timeout <= 1'b0;
        end else begin
            div_start <= 1'b0;
            div_clear <= 1'b0;
            if (flush) begin
                state     <= IDLE;
                wb_valid  <= 1'b0;
                div_clear <= state == LAUNCH || state == WAIT;
            end else if (accept) begin
                state     <= LAUNCH;
                div_start <= 1'b1;
                wb_valid  <= 1'b0;
                div_op    <= req_op;
                div_a     <= req_a;
                div_b     <= req_b;
                wb_rd     <= req_rd;
                wb_ctrl   <= req_ctrl;
            end else begin
                case (state)
                    LAUNCH: begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                    WAIT: begin
                        cnt <= cnt + 7'd1;
                        if (div_done) begin
                            wb_data  <= div_result;
                            wb_valid <= 1'b1;
                            state    <= HOLD;
                        end else if (cnt == LAST) begin
                            div_clear   <= 1'b1;
                            err_timeout <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                    HOLD: begin
                        if (wb_ready) begin
                            wb_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed and randomized checks of div_issue_ctrl against a transaction-level
// model, with the bench playing the iterative divider (configurable latency, spurious and clear-echo dones).
module tb_div_issue_ctrl;
    localparam int W = 32, CW = 64, TO = 40;
    logic clk = 0, rst = 1, flush = 0, req_valid = 0, wb_ready = 0;
    logic [1:0] req_op = 0;
    logic [W-1:0] req_a = 0, req_b = 0, div_result = 0;
    logic [4:0] req_rd = 0, rs1 = 0, rs2 = 0;
    logic [CW-1:0] req_ctrl = 0;
    logic use_rs1 = 0, use_rs2 = 0, div_done = 0;
    logic req_ready, hazard_stall, div_start, div_clear, wb_valid, err_timeout;
    logic [1:0] div_op;
    logic [W-1:0] div_a, div_b, wb_data;
    logic [4:0] wb_rd;
    logic [CW-1:0] wb_ctrl;

    div_issue_ctrl #(.WIDTH(W), .CTRL_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .req_ctrl(req_ctrl),
        .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2), .hazard_stall(hazard_stall),
        .div_start(div_start), .div_op(div_op), .div_a(div_a), .div_b(div_b), .div_clear(div_clear),
        .div_done(div_done), .div_result(div_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_ctrl(wb_ctrl), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 launching, 2 divider busy, 3 result held
    int m_phase, m_cnt, lat, next_lat, tests, fails;
    bit m_clr, m_err, clr_d;
    logic [1:0] m_op;
    logic [W-1:0] m_a, m_b, m_data;
    logic [4:0] m_rd;
    logic [CW-1:0] m_ctrl;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFFFFFF;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : a;
        case (op)
            2'd0: return sa / sb;
            2'd1: return a / b;
            2'd2: return sa % sb;
            default: return a % b;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_clr = 0; m_err = 0; clr_d = 0; lat = -1;
        m_op = 0; m_a = 0; m_b = 0; m_data = 0; m_rd = 0; m_ctrl = 0;
    endtask

    // Called at a falling edge with inputs set; checks outputs, then advances one clock.
    task automatic step();
        bit exp_rr, busy, exp_hz;
        div_result = $urandom;
        if (clr_d) div_done = 1;
        else if (m_phase == 2) div_done = (m_cnt == lat);
        else div_done = ($urandom_range(7) == 0);
        if (m_phase == 2 && m_cnt == lat) div_result = ref_div(m_op, m_a, m_b);
        #1;
        exp_rr = !flush && (m_phase == 0 || (m_phase == 3 && wb_ready));
        busy = m_phase == 1 || m_phase == 2 || (m_phase == 3 && !wb_ready);
        exp_hz = busy && m_rd != 0 && ((use_rs1 && rs1 == m_rd) || (use_rs2 && rs2 == m_rd));
        check("req_ready", req_ready, exp_rr);
        check("hazard_stall", hazard_stall, exp_hz);
        check("div_start", div_start, m_phase == 1);
        check("div_clear", div_clear, m_clr);
        check("wb_valid", wb_valid, m_phase == 3);
        check("err_timeout", err_timeout, m_err);
        if (m_phase == 1) begin
            check("div_op", div_op, m_op);
            check("div_a", div_a, m_a);
            check("div_b", div_b, m_b);
        end
        if (m_phase == 3) begin
            check("wb_data", wb_data, m_data);
            check("wb_rd", wb_rd, m_rd);
            check("wb_ctrl", wb_ctrl, m_ctrl);
        end
        @(posedge clk);
        clr_d = m_clr;
        m_clr = 0;
        if (flush) begin
            m_clr = m_phase == 1 || m_phase == 2;
            m_phase = 0;
        end else if (exp_rr && req_valid) begin
            m_op = req_op; m_a = req_a; m_b = req_b; m_rd = req_rd; m_ctrl = req_ctrl;
            lat = next_lat;
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_cnt = 0;
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (div_done) begin
                m_data = div_result;
                m_phase = 3;
            end else if (m_cnt == TO - 1) begin
                m_clr = 1;
                m_err = 1;
                m_phase = 0;
            end else m_cnt++;
        end else if (m_phase == 3 && wb_ready) m_phase = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; flush = 0; req_valid = 0; wb_ready = 0; div_done = 0; use_rs1 = 0; use_rs2 = 0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_div_start", div_start, 0);
        check("rst_div_clear", div_clear, 0);
        check("rst_err", err_timeout, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_hazard", hazard_stall, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] rd, input int l);
        req_valid = 1; req_op = op; req_a = a; req_b = b; req_rd = rd;
        req_ctrl = {$urandom, $urandom};
        next_lat = l;
        step();
        req_valid = 0;
    endtask

    task automatic wait_hold();
        for (int i = 0; i < 60 && m_phase != 3; i++) step();
        #1 check("reach_hold", wb_valid, 1);
    endtask

    task automatic release_wb();
        wb_ready = 1;
        step();
        wb_ready = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        // 1: signed divide
        launch(2'd0, 32'hFFFFFFF9, 32'd2, 5'd5, 3);
        wait_hold();
        check("t1_data", wb_data, 32'hFFFFFFFD);
        check("t1_rd", wb_rd, 5);
        release_wb();
        // 2: divide by zero and overflow pass straight through
        launch(2'd3, 32'd7, 32'd0, 5'd6, 1);
        wait_hold();
        check("t2_remu0", wb_data, 32'h7);
        release_wb();
        launch(2'd0, 32'h80000000, 32'hFFFFFFFF, 5'd7, 2);
        wait_hold();
        check("t2_ovf", wb_data, 32'h80000000);
        release_wb();
        // 3: back-to-back issue from HOLD
        launch(2'd2, 32'd100, 32'd7, 5'd8, 2);
        wait_hold();
        wb_ready = 1; req_valid = 1; req_op = 2'd2; req_a = 17; req_b = 5; req_rd = 9; next_lat = 1;
        step();
        req_valid = 0; wb_ready = 0;
        #1 check("t3_start", div_start, 1);
        check("t3_a", div_a, 17);
        wait_hold();
        check("t3_data", wb_data, 32'h2);
        release_wb();
        // 4: hazard detection
        launch(2'd1, 32'd50, 32'd3, 5'd5, 6);
        step(); step();
        rs1 = 5; use_rs1 = 1;
        #1 check("t4_hz", hazard_stall, 1);
        use_rs1 = 0;
        #1 check("t4_nouse", hazard_stall, 0);
        use_rs1 = 1;
        wait_hold();
        wb_ready = 1;
        #1 check("t4_wbdrop", hazard_stall, 0);
        step();
        wb_ready = 0;
        rs1 = 0;
        launch(2'd1, 32'd50, 32'd3, 5'd0, 3);
        #1 check("t4_rd0", hazard_stall, 0);
        wait_hold();
        use_rs1 = 0;
        release_wb();
        // 5: flush in WAIT
        launch(2'd0, 32'd100, 32'd3, 5'd4, 100);
        for (int i = 0; i < 10; i++) step();
        flush = 1;
        step();
        flush = 0;
        #1 check("t5_clear", div_clear, 1);
        step();
        check("t5_nowb", wb_valid, 0);
        check("t5_ready", req_ready, 1);
        // 6: watchdog
        launch(2'd1, 32'd9, 32'd3, 5'd3, -1);
        for (int i = 0; i < 45; i++) step();
        check("t6_err", err_timeout, 1);
        check("t6_ready", req_ready, 1);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(499) == 0) do_reset();
            req_valid = $urandom_range(1);
            req_op = 2'($urandom);
            req_a = ($urandom_range(7) == 0) ? 32'h80000000 : $urandom;
            req_b = ($urandom_range(5) == 0) ? 32'h0 : ($urandom_range(7) == 0) ? 32'hFFFFFFFF : $urandom;
            req_rd = 5'($urandom);
            req_ctrl = {$urandom, $urandom};
            wb_ready = $urandom_range(1);
            flush = $urandom_range(29) == 0;
            rs1 = $urandom_range(1) ? m_rd : 5'($urandom);
            rs2 = $urandom_range(1) ? m_rd : 5'($urandom);
            use_rs1 = $urandom_range(1);
            use_rs2 = $urandom_range(1);
            next_lat = ($urandom_range(19) == 0) ? 45 : $urandom_range(5);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
